// File: rtl/jk_cmd_seq.sv
// Queued j/k command sequencer feeding the JK flip-flop FSM: a FIFO of {op, hold} plus a two-state player.
// Optional feature: define JK_SEQ_CNT_EN to add the 8-bit done_cnt output.
module jk_cmd_seq #(
    parameter int HOLD_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [HOLD_W-1:0] cmd_hold,
    output logic              j,
    output logic              k,
    output logic              busy,
    output logic              done_pulse
`ifdef JK_SEQ_CNT_EN
    ,
    output logic [7:0]        done_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [HOLD_W+1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [0:0]        state;
    logic [HOLD_W-1:0] cnt;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              last_cycle;
    logic [1:0]        head_op;
    logic [HOLD_W-1:0] head_hold;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign cmd_ready  = !full && !rst;
    assign push       = cmd_valid && cmd_ready;
    assign last_cycle = (state == ST_DRIVE) && (cnt == '0);
    assign pop        = !empty && ((state == ST_IDLE) || last_cycle);
    assign head_op    = mem[rd_ptr][HOLD_W+1:HOLD_W];
    assign head_hold  = mem[rd_ptr][HOLD_W-1:0];
    assign busy       = (state == ST_DRIVE) || !empty;

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // done_pulse is registered, so it is precomputed one cycle ahead from the count about to be held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            j          <= 1'b0;
            k          <= 1'b0;
            cnt        <= '0;
            done_pulse <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_pulse <= 1'b0;
                    if (pop) begin
                        state      <= ST_DRIVE;
                        {j, k}     <= head_op;
                        cnt        <= head_hold;
                        done_pulse <= (head_hold == '0);
                    end
                end
                ST_DRIVE: begin
                    if (cnt != '0) begin
                        cnt        <= cnt - HOLD_W'(1);
                        done_pulse <= (cnt == HOLD_W'(1));
                    end else if (pop) begin
                        {j, k}     <= head_op;
                        cnt        <= head_hold;
                        done_pulse <= (head_hold == '0);
                    end else begin
                        state      <= ST_IDLE;
                        j          <= 1'b0;
                        k          <= 1'b0;
                        done_pulse <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    j          <= 1'b0;
                    k          <= 1'b0;
                    done_pulse <= 1'b0;
                end
            endcase
        end
    end

`ifdef JK_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= 8'd0;
        end else if (done_pulse) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
`endif

endmodule
